// File: rtl/mem_block_ctrl.sv
// Cache-block mover: optionally writes back a dirty victim block, then fills a new
// block from the external memory, one word per cycle, with all memory-side outputs registered.
module mem_block_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 64,
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic                                  clk,
    input  logic                                  arstn,
    input  logic                                  i_start,
    input  logic                                  i_wb_en,
    input  logic [ADDR_WIDTH-1:0]                 i_fill_addr,
    input  logic [ADDR_WIDTH-1:0]                 i_wb_addr,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] i_wb_block,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] o_fill_block,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_mem_we,
    output logic [ADDR_WIDTH-1:0]                 o_mem_addr,
    output logic [DATA_WIDTH-1:0]                 o_mem_data,
    input  logic [DATA_WIDTH-1:0]                 i_mem_data
);

    localparam int KW   = $clog2(WORDS_PER_BLOCK);
    localparam int OFFS = KW + 2;
    localparam int BW   = DATA_WIDTH * WORDS_PER_BLOCK;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [KW-1:0]         K_LAST    = KW'(WORDS_PER_BLOCK - 1);
    localparam logic [KW-1:0]         K_ONE     = KW'(1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

    logic [1:0]            state_r, state_nxt_s;
    logic [KW-1:0]         k_r, k_nxt_s;
    logic [ADDR_WIDTH-1:0] base_fill_r, base_fill_nxt_s;
    logic [ADDR_WIDTH-1:0] base_wb_r, base_wb_nxt_s;
    logic [BW-1:0]         wb_block_r, wb_block_nxt_s;
    logic [BW-1:0]         fill_block_r;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  mem_we_r, mem_we_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0] mem_data_r, mem_data_nxt_s;

    // Next state, word counter and request latching.
    always_comb begin
        state_nxt_s     = state_r;
        k_nxt_s         = k_r;
        base_fill_nxt_s = base_fill_r;
        base_wb_nxt_s   = base_wb_r;
        wb_block_nxt_s  = wb_block_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s     = i_wb_en ? ST_WRITE : ST_READ;
                    k_nxt_s         = {KW{1'b0}};
                    base_fill_nxt_s = i_fill_addr & BASE_MASK;
                    base_wb_nxt_s   = i_wb_addr & BASE_MASK;
                    wb_block_nxt_s  = i_wb_block;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (k_r == K_LAST) begin
                    k_nxt_s     = {KW{1'b0}};
                    state_nxt_s = ST_READ;
                end else begin
                    k_nxt_s = k_r + K_ONE;
                end
            end
            ST_READ: begin
                if (k_r == K_LAST) begin
                    k_nxt_s     = {KW{1'b0}};
                    state_nxt_s = ST_DONE;
                end else begin
                    k_nxt_s = k_r + K_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                k_nxt_s     = {KW{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, decoded from next state/k so the ports stay registered.
    always_comb begin
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        done_nxt_s     = (state_nxt_s == ST_DONE);
        mem_we_nxt_s   = (state_nxt_s == ST_WRITE);
        mem_addr_nxt_s = {ADDR_WIDTH{1'b0}};
        mem_data_nxt_s = {DATA_WIDTH{1'b0}};
        case (state_nxt_s)
            ST_WRITE: begin
                // Base has a zero offset field, so OR-ing k in can never leave the block.
                mem_addr_nxt_s = base_wb_nxt_s | {{(ADDR_WIDTH-OFFS){1'b0}}, k_nxt_s, 2'b00};
                mem_data_nxt_s = wb_block_nxt_s[DATA_WIDTH*int'(k_nxt_s) +: DATA_WIDTH];
            end
            ST_READ: begin
                mem_addr_nxt_s = base_fill_nxt_s | {{(ADDR_WIDTH-OFFS){1'b0}}, k_nxt_s, 2'b00};
            end
            default: begin
                mem_addr_nxt_s = {ADDR_WIDTH{1'b0}};
                mem_data_nxt_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // State, latched request and registered outputs; READ captures the word addressed this cycle.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r      <= ST_IDLE;
            k_r          <= {KW{1'b0}};
            base_fill_r  <= {ADDR_WIDTH{1'b0}};
            base_wb_r    <= {ADDR_WIDTH{1'b0}};
            wb_block_r   <= {BW{1'b0}};
            fill_block_r <= {BW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            base_fill_r <= base_fill_nxt_s;
            base_wb_r   <= base_wb_nxt_s;
            wb_block_r  <= wb_block_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_data_r  <= mem_data_nxt_s;
            if (state_r == ST_READ) begin
                fill_block_r[DATA_WIDTH*int'(k_r) +: DATA_WIDTH] <= i_mem_data;
            end
        end
    end

    assign o_fill_block = fill_block_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_mem_we     = mem_we_r;
    assign o_mem_addr   = mem_addr_r;
    assign o_mem_data   = mem_data_r;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl: small word memory model, cycle-by-cycle port checks,
// memory readback after writebacks, async reset mid-writeback.
module tb_mem_block_ctrl;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int W  = 16;
    localparam int BW = DW * W;

    logic          clk = 1'b0;
    logic          arstn;
    logic          i_start;
    logic          i_wb_en;
    logic [AW-1:0] i_fill_addr;
    logic [AW-1:0] i_wb_addr;
    logic [BW-1:0] i_wb_block;
    logic [BW-1:0] o_fill_block;
    logic          o_busy;
    logic          o_done;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic [DW-1:0] i_mem_data;

    logic [31:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_idx;
    logic [31:0] pre_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_block_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_BLOCK(W)) dut (
        .clk(clk), .arstn(arstn), .i_start(i_start), .i_wb_en(i_wb_en),
        .i_fill_addr(i_fill_addr), .i_wb_addr(i_wb_addr), .i_wb_block(i_wb_block),
        .o_fill_block(o_fill_block), .o_busy(o_busy), .o_done(o_done),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .i_mem_data(i_mem_data)
    );

    always #5 clk = ~clk;

    // Word memory indexed by address bits [13:2]; the bench preloads it through the same port.
    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_addr[13:2]] <= o_mem_data;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end
    assign i_mem_data = mem[o_mem_addr[13:2]];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pat(input logic [31:0] seed);
        logic [BW-1:0] r;
        for (int k = 0; k < W; k++) r[k*DW +: DW] = seed + 32'(k);
        return r;
    endfunction

    task automatic preload(input logic [11:0] idx, input logic [31:0] seed);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_idx  = idx + 12'(k);
            pre_data = seed + 32'(k);
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
        check({tag, "_we"},   64'(o_mem_we), 64'd0);
        check({tag, "_addr"}, o_mem_addr, 64'd0);
        check({tag, "_data"}, 64'(o_mem_data), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge of the o_done cycle.
    task automatic xfer(input logic wb_en, input logic [AW-1:0] fa, input logic [AW-1:0] wa,
                        input logic [BW-1:0] blk, input logic [AW-1:0] exp_fb,
                        input logic [AW-1:0] exp_wb, input logic [BW-1:0] exp_fill,
                        input bit hold);
        int nw;
        i_wb_en     = wb_en;
        i_fill_addr = fa;
        i_wb_addr   = wa;
        i_wb_block  = blk;
        i_start     = 1'b1;
        @(negedge clk);
        if (hold) begin
            i_fill_addr = 64'h9999_0000;
            i_wb_addr   = 64'h8888_0000;
            i_wb_en     = ~wb_en;
            i_wb_block  = ~blk;
        end else begin
            i_start = 1'b0;
        end
        nw = wb_en ? W : 0;
        for (int c = 0; c < nw; c++) begin
            check($sformatf("wr_busy[%0d]", c), 64'(o_busy), 64'd1);
            check($sformatf("wr_we[%0d]", c), 64'(o_mem_we), 64'd1);
            check($sformatf("wr_addr[%0d]", c), o_mem_addr, exp_wb + 64'(4 * c));
            check($sformatf("wr_data[%0d]", c), 64'(o_mem_data), 64'(blk[c*DW +: DW]));
            @(negedge clk);
        end
        for (int c = 0; c < W; c++) begin
            check($sformatf("rd_busy[%0d]", c), 64'(o_busy), 64'd1);
            check($sformatf("rd_done[%0d]", c), 64'(o_done), 64'd0);
            check($sformatf("rd_we[%0d]", c), 64'(o_mem_we), 64'd0);
            check($sformatf("rd_addr[%0d]", c), o_mem_addr, exp_fb + 64'(4 * c));
            @(negedge clk);
        end
        check("done_pulse", 64'(o_done), 64'd1);
        check("done_busy", 64'(o_busy), 64'd1);
        check("done_we", 64'(o_mem_we), 64'd0);
        check("done_addr", o_mem_addr, 64'd0);
        for (int k = 0; k < W; k++)
            check($sformatf("fill_word[%0d]", k), 64'(o_fill_block[k*DW +: DW]),
                  64'(exp_fill[k*DW +: DW]));
    endtask

    initial begin
        arstn       = 1'b0;
        i_start     = 1'b0;
        i_wb_en     = 1'b0;
        i_fill_addr = 64'd0;
        i_wb_addr   = 64'd0;
        i_wb_block  = '0;
        pre_we      = 1'b0;
        pre_idx     = 12'd0;
        pre_data    = 32'd0;
        #12;
        check_idle("reset");
        check("reset_fill", 64'(o_fill_block[DW-1:0]), 64'd0);
        @(negedge clk);
        arstn = 1'b1;

        preload(12'h480, 32'hA000_0000);   // 0x1200
        preload(12'hC00, 32'h3300_0000);   // 0x3000
        preload(12'h400, 32'h1100_0000);   // 0x5000
        preload(12'hFF0, 32'hEE00_0000);   // 0x...FFC0

        // Fill only
        xfer(1'b0, 64'h1234, 64'h0, '0, 64'h1200, 64'h0, pat(32'hA000_0000), 1'b0);
        @(negedge clk); check_idle("t1_idle");

        // Writeback then fill, with memory readback of the victim
        xfer(1'b1, 64'h3000, 64'h2040, pat(32'h5500_0000), 64'h3000, 64'h2040,
             pat(32'h3300_0000), 1'b0);
        @(negedge clk); check_idle("t2_idle");
        for (int k = 0; k < W; k++)
            check($sformatf("t2_mem[%0d]", k), 64'(mem[12'h810 + 12'(k)]), 64'(32'h5500_0000 + 32'(k)));

        // Same block written back and refilled
        xfer(1'b1, 64'h4010, 64'h4010, pat(32'h7700_0000), 64'h4000, 64'h4000,
             pat(32'h7700_0000), 1'b0);
        @(negedge clk); check_idle("t3_idle");

        // i_start held and inputs scrambled; back-to-back request one cycle after o_done
        xfer(1'b0, 64'h1234, 64'h0, '0, 64'h1200, 64'h0, pat(32'hA000_0000), 1'b1);
        @(negedge clk);
        check("t4_gap_busy", 64'(o_busy), 64'd0);
        check("t4_gap_we", 64'(o_mem_we), 64'd0);
        // Top-of-space fill accepted at the end of this idle cycle
        xfer(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, '0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0,
             pat(32'hEE00_0000), 1'b0);
        check("t5_last_fill", 64'(o_fill_block[15*DW +: DW]), 64'hEE00_000F);
        @(negedge clk); check_idle("t5_idle");

        // Async reset during WRITE cycle 5
        i_wb_en     = 1'b1;
        i_fill_addr = 64'h3000;
        i_wb_addr   = 64'h5000;
        i_wb_block  = pat(32'h6600_0000);
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_c5_we", 64'(o_mem_we), 64'd1);
        check("t6_c5_addr", o_mem_addr, 64'h5010);
        arstn = 1'b0;
        #1;
        check_idle("t6_rst");
        check("t6_rst_fill", 64'(o_fill_block[DW-1:0]), 64'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk); check_idle("t6_after");
        for (int k = 0; k < 4; k++)
            check($sformatf("t6_written[%0d]", k), 64'(mem[12'h400 + 12'(k)]), 64'(32'h6600_0000 + 32'(k)));
        for (int k = 5; k < W; k++)
            check($sformatf("t6_kept[%0d]", k), 64'(mem[12'h400 + 12'(k)]), 64'(32'h1100_0000 + 32'(k)));

        // Normal request after the aborted one
        xfer(1'b1, 64'h1234, 64'h5000, pat(32'h6600_0000), 64'h1200, 64'h5000,
             pat(32'hA000_0000), 1'b0);
        @(negedge clk); check_idle("t7_idle");
        for (int k = 0; k < W; k++)
            check($sformatf("t7_mem[%0d]", k), 64'(mem[12'h400 + 12'(k)]), 64'(32'h6600_0000 + 32'(k)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
